// File: rtl/fft8_frame_loader.sv
// Serial-to-parallel loader for the 8-point FFT: collects eight complex samples
// into a fill buffer and copies them atomically to held output registers.
module fft8_frame_loader #(
   parameter int DW   = 5,
   parameter int HOLD = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_re,
   input  logic [DW-1:0] s_im,
   input  logic          s_last,
   output logic [DW-1:0] x_r_0,
   output logic [DW-1:0] x_r_1,
   output logic [DW-1:0] x_r_2,
   output logic [DW-1:0] x_r_3,
   output logic [DW-1:0] x_r_4,
   output logic [DW-1:0] x_r_5,
   output logic [DW-1:0] x_r_6,
   output logic [DW-1:0] x_r_7,
   output logic [DW-1:0] x_i_0,
   output logic [DW-1:0] x_i_1,
   output logic [DW-1:0] x_i_2,
   output logic [DW-1:0] x_i_3,
   output logic [DW-1:0] x_i_4,
   output logic [DW-1:0] x_i_5,
   output logic [DW-1:0] x_i_6,
   output logic [DW-1:0] x_i_7,
   output logic          frame_stb,
   output logic          err_sync,
   output logic [7:0]    frame_cnt
);

   // ST_IDLE exists only so s_ready is low during reset and rises one edge later.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_WAIT
   } state_t;

   localparam logic [7:0] HOLD_C   = 8'(HOLD);
   localparam logic [7:0] HOLD_SAT = 8'hFF;
   localparam logic [2:0] IDX_LAST = 3'd7;

   state_t        state;
   state_t        state_nxt;
   logic [2:0]    idx;
   logic [7:0]    hold_cnt;
   logic          hold_ok;
   logic          accept;
   logic          load;
   logic          early_last;

   logic [DW-1:0] fill_re [8];
   logic [DW-1:0] fill_im [8];
   logic [DW-1:0] out_re  [8];
   logic [DW-1:0] out_im  [8];

   // hold_cnt is the number of edges elapsed since the last load, counting the coming edge.
   assign hold_ok    = (hold_cnt >= HOLD_C);
   assign early_last = accept && s_last && (idx != IDX_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: state_nxt = ST_FILL;
         ST_FILL: if (accept && (idx == IDX_LAST)) state_nxt = ST_WAIT;
         ST_WAIT: if (hold_ok) state_nxt = ST_FILL;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      s_ready = (state == ST_FILL);
      accept  = s_ready && s_valid;
      load    = (state == ST_WAIT) && hold_ok;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         hold_cnt  <= HOLD_SAT;
         frame_stb <= 1'b0;
         err_sync  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         frame_stb <= load;
         err_sync  <= early_last;

         if (load) begin
            idx <= '0;
         end else if (accept) begin
            idx <= early_last ? 3'd0 : idx + 3'd1;
         end

         if (load) begin
            hold_cnt <= 8'd1;
         end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + 8'd1;
         end

         if (load) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   // NOTE: the fill buffer is left unreset on purpose; every slot is rewritten before it can be loaded.
   always_ff @(posedge clk) begin
      if (accept) begin
         fill_re[idx] <= s_re;
         fill_im[idx] <= s_im;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 8; k++) begin
            out_re[k] <= '0;
            out_im[k] <= '0;
         end
      end else if (load) begin
         out_re <= fill_re;
         out_im <= fill_im;
      end
   end

   assign x_r_0 = out_re[0];
   assign x_r_1 = out_re[1];
   assign x_r_2 = out_re[2];
   assign x_r_3 = out_re[3];
   assign x_r_4 = out_re[4];
   assign x_r_5 = out_re[5];
   assign x_r_6 = out_re[6];
   assign x_r_7 = out_re[7];
   assign x_i_0 = out_im[0];
   assign x_i_1 = out_im[1];
   assign x_i_2 = out_im[2];
   assign x_i_3 = out_im[3];
   assign x_i_4 = out_im[4];
   assign x_i_5 = out_im[5];
   assign x_i_6 = out_im[6];
   assign x_i_7 = out_im[7];

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Directed bench for fft8_frame_loader: one instance at HOLD=9, one at HOLD=12,
// sharing sample/reset stimulus; sel steers s_valid and the observed outputs.
module tb_fft8_frame_loader;

   // Frames are packed slot 0 first (most significant 5 bits).
   localparam logic [39:0] F_A_R = {5'd14, 5'd0, 5'd6, 5'd0, 5'd5, 5'd0, 5'd15, 5'd0};
   localparam logic [39:0] F_B_R = {8{5'd5}};
   localparam logic [39:0] F_C_R = {5'h18, 5'h19, 5'h1A, 5'h1B, 5'h1C, 5'h1D, 5'h1E, 5'h1F};
   localparam logic [39:0] F_C_I = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
   localparam logic [39:0] F_D_R = {5'd3, 5'd1, 5'd4, 5'd1, 5'd5, 5'd9, 5'd2, 5'd6};
   localparam logic [39:0] F_D_I = {5'h10, 5'd15, 5'd0, 5'h1F, 5'd1, 5'd2, 5'd3, 5'd4};
   localparam logic [39:0] F_P_R = {8{5'd9}};
   localparam logic [39:0] F_E_R = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
   localparam logic [39:0] F_E_I = {5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
   localparam logic [39:0] F_R_R = {8{5'd11}};
   localparam logic [39:0] F_G_R = {5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'h1D, 5'h1B};
   localparam logic [39:0] F_G_I = {5'd1, 5'd0, 5'd1, 5'd0, 5'd1, 5'd0, 5'd1, 5'd0};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;
   logic       sel = 1'b0;
   logic [4:0] s_re = '0;
   logic [4:0] s_im = '0;
   logic       v_a, v_b;
   logic       rdy_a, rdy_b, stb_a, stb_b, err_a, err_b;
   logic [7:0] cnt_a, cnt_b;
   logic [4:0] xr_a [8];
   logic [4:0] xi_a [8];
   logic [4:0] xr_b [8];
   logic [4:0] xi_b [8];

   logic        rdy, stb, err;
   logic [7:0]  cnt;
   logic [39:0] snap_r, snap_i;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int last_wait = 0;
   int frame_wait = 0;
   int stb_q [$];
   logic [39:0] sr_q [$];
   logic [39:0] si_q [$];
   logic [7:0]  cnt_q [$];
   int err_total = 0;
   int err_cyc = -1;
   int unexp_chg = 0;
   logic [39:0] prev_r = '0;
   logic [39:0] prev_i = '0;
   logic        prev_sel = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign v_a = s_valid & ~sel;
   assign v_b = s_valid & sel;

   fft8_frame_loader #(.DW(5), .HOLD(9)) u_a (
      .clk(clk), .rst_n(rst_n), .s_valid(v_a), .s_ready(rdy_a),
      .s_re(s_re), .s_im(s_im), .s_last(s_last),
      .x_r_0(xr_a[0]), .x_r_1(xr_a[1]), .x_r_2(xr_a[2]), .x_r_3(xr_a[3]),
      .x_r_4(xr_a[4]), .x_r_5(xr_a[5]), .x_r_6(xr_a[6]), .x_r_7(xr_a[7]),
      .x_i_0(xi_a[0]), .x_i_1(xi_a[1]), .x_i_2(xi_a[2]), .x_i_3(xi_a[3]),
      .x_i_4(xi_a[4]), .x_i_5(xi_a[5]), .x_i_6(xi_a[6]), .x_i_7(xi_a[7]),
      .frame_stb(stb_a), .err_sync(err_a), .frame_cnt(cnt_a)
   );

   fft8_frame_loader #(.DW(5), .HOLD(12)) u_b (
      .clk(clk), .rst_n(rst_n), .s_valid(v_b), .s_ready(rdy_b),
      .s_re(s_re), .s_im(s_im), .s_last(s_last),
      .x_r_0(xr_b[0]), .x_r_1(xr_b[1]), .x_r_2(xr_b[2]), .x_r_3(xr_b[3]),
      .x_r_4(xr_b[4]), .x_r_5(xr_b[5]), .x_r_6(xr_b[6]), .x_r_7(xr_b[7]),
      .x_i_0(xi_b[0]), .x_i_1(xi_b[1]), .x_i_2(xi_b[2]), .x_i_3(xi_b[3]),
      .x_i_4(xi_b[4]), .x_i_5(xi_b[5]), .x_i_6(xi_b[6]), .x_i_7(xi_b[7]),
      .frame_stb(stb_b), .err_sync(err_b), .frame_cnt(cnt_b)
   );

   always_comb begin
      rdy    = sel ? rdy_b : rdy_a;
      stb    = sel ? stb_b : stb_a;
      err    = sel ? err_b : err_a;
      cnt    = sel ? cnt_b : cnt_a;
      snap_r = sel ? {xr_b[0], xr_b[1], xr_b[2], xr_b[3], xr_b[4], xr_b[5], xr_b[6], xr_b[7]}
                   : {xr_a[0], xr_a[1], xr_a[2], xr_a[3], xr_a[4], xr_a[5], xr_a[6], xr_a[7]};
      snap_i = sel ? {xi_b[0], xi_b[1], xi_b[2], xi_b[3], xi_b[4], xi_b[5], xi_b[6], xi_b[7]}
                   : {xi_a[0], xi_a[1], xi_a[2], xi_a[3], xi_a[4], xi_a[5], xi_a[6], xi_a[7]};
   end

   // Record every load and flag any output change that is not accompanied by frame_stb.
   always @(negedge clk) begin
      if (rst_n) begin
         if (stb) begin
            stb_q.push_back(cyc);
            sr_q.push_back(snap_r);
            si_q.push_back(snap_i);
            cnt_q.push_back(cnt);
         end else if (sel == prev_sel && (snap_r !== prev_r || snap_i !== prev_i)) begin
            unexp_chg++;
         end
         if (err) begin
            err_total++;
            err_cyc = cyc;
         end
      end
      prev_r   = snap_r;
      prev_i   = snap_i;
      prev_sel = sel;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic push(input logic [4:0] re, input logic [4:0] im, input logic last, input bit bubble);
      int w;
      s_re    = re;
      s_im    = im;
      s_last  = last;
      s_valid = 1'b1;
      w = 0;
      while (!rdy && w < 200) begin
         @(negedge clk);
         w++;
      end
      last_wait = w;
      if (w >= 200) check("ready_timeout", {63'd0, rdy}, 64'd1);
      @(negedge clk);
      acc_cyc = cyc;
      if (bubble) begin
         s_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic push_frame(input logic [39:0] vr, input logic [39:0] vi, input int n,
                             input int last_at, input bit bubble);
      for (int i = 0; i < n; i++) begin
         push(vr[(7-i)*5 +: 5], vi[(7-i)*5 +: 5], (i == last_at), bubble);
         if (i == 0) frame_wait = last_wait;
      end
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int b, e8, ep, e0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ready", {63'd0, rdy_a}, 64'd0);
      check("rst_x", {24'd0, snap_r}, 64'd0);
      check("rst_stb_err", {62'd0, stb_a, err_a}, 64'd0);
      check("rst_cnt", {56'd0, cnt_a}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_release", {63'd0, rdy_a}, 64'd1);

      // Basic frame followed by a back-to-back continuous frame (HOLD=9)
      b = stb_q.size();
      push_frame(F_A_R, 40'd0, 8, 7, 1'b0);
      e8 = acc_cyc;
      push_frame(F_B_R, 40'd0, 8, 7, 1'b0);
      check("ready_low_cycles", 64'(frame_wait), 64'd1);
      idle(4);
      check("load_count_ab", 64'(stb_q.size() - b), 64'd2);
      check("basic_stb_latency", 64'(stb_q[b]), 64'(e8 + 1));
      check("basic_data_r", {24'd0, sr_q[b]}, {24'd0, F_A_R});
      check("basic_data_i", {24'd0, si_q[b]}, 64'd0);
      check("basic_cnt", {56'd0, cnt_q[b]}, 64'd1);
      check("cont_load_gap", 64'(stb_q[b+1] - stb_q[b]), 64'd9);
      check("cont_data_r", {24'd0, sr_q[b+1]}, {24'd0, F_B_R});
      check("cont_cnt", {56'd0, cnt_a}, 64'd2);
      check("hold_stable_ab", 64'(unexp_chg), 64'd0);

      // Bubbles and backpressure on the HOLD=12 instance
      sel = 1'b1;
      @(negedge clk);
      b = stb_q.size();
      push_frame(F_C_R, F_C_I, 8, 7, 1'b1);
      push_frame(F_D_R, F_D_I, 8, 7, 1'b0);
      push(5'd1, 5'd1, 1'b0, 1'b0);
      check("hold12_ready_low", 64'(last_wait), 64'd4);
      idle(3);
      check("load_count_cd", 64'(stb_q.size() - b), 64'd2);
      check("hold12_gap", 64'(stb_q[b+1] - stb_q[b]), 64'd12);
      check("hold12_accept_after_load", 64'(acc_cyc), 64'(stb_q[b+1] + 1));
      check("bubble_data_r", {24'd0, sr_q[b]}, {24'd0, F_C_R});
      check("bubble_data_i", {24'd0, si_q[b]}, {24'd0, F_C_I});
      check("hold12_data_r", {24'd0, sr_q[b+1]}, {24'd0, F_D_R});
      check("hold12_data_i", {24'd0, si_q[b+1]}, {24'd0, F_D_I});
      check("hold12_cnt", {56'd0, cnt_b}, 64'd2);
      sel = 1'b0;
      @(negedge clk);

      // Early s_last on the 3rd sample, then a full frame
      b  = stb_q.size();
      e0 = err_total;
      push_frame(F_P_R, F_P_R, 3, 2, 1'b0);
      ep = acc_cyc;
      push_frame(F_E_R, F_E_I, 8, 7, 1'b0);
      idle(4);
      check("early_err_count", 64'(err_total - e0), 64'd1);
      check("early_err_timing", 64'(err_cyc), 64'(ep));
      check("early_load_count", 64'(stb_q.size() - b), 64'd1);
      check("early_next_data_r", {24'd0, sr_q[b]}, {24'd0, F_E_R});
      check("early_next_data_i", {24'd0, si_q[b]}, {24'd0, F_E_I});
      check("early_cnt", {56'd0, cnt_a}, 64'd3);

      // Asynchronous reset after 5 accepts
      push_frame(F_R_R, F_R_R, 5, -1, 1'b0);
      s_valid = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_x_r", {24'd0, snap_r}, 64'd0);
      check("midrst_x_i", {24'd0, snap_i}, 64'd0);
      check("midrst_flags", {61'd0, rdy_a, stb_a, err_a}, 64'd0);
      check("midrst_cnt", {56'd0, cnt_a}, 64'd0);
      repeat (2) @(negedge clk);
      check("midrst_ready_held", {63'd0, rdy_a}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      b = stb_q.size();
      push_frame(F_G_R, F_G_I, 8, 7, 1'b0);
      idle(4);
      check("post_rst_load_count", 64'(stb_q.size() - b), 64'd1);
      check("post_rst_data_r", {24'd0, sr_q[b]}, {24'd0, F_G_R});
      check("post_rst_data_i", {24'd0, si_q[b]}, {24'd0, F_G_I});
      check("post_rst_cnt", {56'd0, cnt_a}, 64'd1);

      // Counter wrap: 256 loads from a clean reset
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      b = stb_q.size();
      for (int f = 0; f < 255; f++) push_frame(F_E_R, F_G_I, 8, 7, 1'b0);
      idle(4);
      check("wrap_cnt_255", {56'd0, cnt_a}, 64'd255);
      push_frame(F_D_R, F_D_I, 8, 7, 1'b0);
      idle(4);
      check("wrap_cnt_0", {56'd0, cnt_a}, 64'd0);
      check("wrap_stb_count", 64'(stb_q.size() - b), 64'd256);
      check("wrap_last_data_r", {24'd0, sr_q[stb_q.size()-1]}, {24'd0, F_D_R});
      check("hold_stable_final", 64'(unexp_chg), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
